// File: rtl/id_ex_stage_pkg.sv
// ===========================================================================
// id_ex_stage_pkg : shared pipeline encodings (operand selects, branch kinds,
//                   RF write-data selects) and the ID/EX control bundle.
// Revision 1.0
// ===========================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam logic       ALU_ASEL_RD1  = 1'b0;
  localparam logic       ALU_ASEL_PC   = 1'b1;

  localparam logic [1:0] ALU_BSEL_RD2  = 2'b00;
  localparam logic [1:0] ALU_BSEL_IMM  = 2'b01;
  localparam logic [1:0] ALU_BSEL_LVRD = 2'b10;

  localparam logic [1:0] BR_NONE       = 2'b00;
  localparam logic [1:0] BR_COND       = 2'b01;
  localparam logic [1:0] BR_JAL        = 2'b10;
  localparam logic [1:0] BR_JALR       = 2'b11;

  localparam logic [1:0] RF_WSEL_ALU   = 2'b00;
  localparam logic [1:0] RF_WSEL_DRAM  = 2'b01;
  localparam logic [1:0] RF_WSEL_PC4   = 2'b10;
  localparam logic [1:0] RF_WSEL_IMM   = 2'b11;

  typedef struct packed {
    logic       alu_asel;
    logic [1:0] alu_bsel;
    logic [3:0] alu_op;
    logic [1:0] rf_we;
    logic [1:0] rf_wsel;
    logic [1:0] ram_we;
    logic       is_load;
    logic [1:0] branch;
  } ctrl_t;

  // A bubble must never write state, so every control field is cleared.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ===========================================================================
// id_ex_stage_if : ID-side inputs, ID/EX register outputs and stall/flush
//                  status of the ID/EX stage.
// Revision 1.0
// ===========================================================================
`default_nettype none

interface id_ex_stage_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [DW-1:0]    id_pc, id_rD1, id_rD2, id_imm;
  logic [4:0]       id_rR1, id_rR2, id_wR;
  logic             id_alu_asel;
  logic [1:0]       id_alu_bsel;
  logic [3:0]       id_alu_op;
  logic [1:0]       id_rf_we, id_rf_wsel, id_ram_we;
  logic             id_is_load;
  logic [1:0]       id_branch;
  logic             ex_br_taken;

  logic             ID_EX_valid;
  logic [DW-1:0]    ID_EX_pc, ID_EX_rD1, ID_EX_rD2, ID_EX_imm;
  logic [4:0]       ID_EX_rR1, ID_EX_rR2, ID_EX_wR;
  logic             ID_EX_alu_asel;
  logic [1:0]       ID_EX_alu_bsel;
  logic [3:0]       ID_EX_alu_op;
  logic [1:0]       ID_EX_rf_we, ID_EX_rf_wsel, ID_EX_ram_we;
  logic             ID_EX_is_load;
  logic [1:0]       ID_EX_branch;

  logic             stall_pc, stall_if_id;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_pc, id_rD1, id_rD2, id_imm, id_rR1, id_rR2, id_wR,
           id_alu_asel, id_alu_bsel, id_alu_op, id_rf_we, id_rf_wsel,
           id_ram_we, id_is_load, id_branch, ex_br_taken,
    input  ID_EX_valid, ID_EX_pc, ID_EX_rD1, ID_EX_rD2, ID_EX_imm,
           ID_EX_rR1, ID_EX_rR2, ID_EX_wR, ID_EX_alu_asel, ID_EX_alu_bsel,
           ID_EX_alu_op, ID_EX_rf_we, ID_EX_rf_wsel, ID_EX_ram_we,
           ID_EX_is_load, ID_EX_branch,
           stall_pc, stall_if_id, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rD1, id_rD2, id_imm, id_rR1, id_rR2, id_wR,
           id_alu_asel, id_alu_bsel, id_alu_op, id_rf_we, id_rf_wsel,
           id_ram_we, id_is_load, id_branch, ex_br_taken,
    output ID_EX_valid, ID_EX_pc, ID_EX_rD1, ID_EX_rD2, ID_EX_imm,
           ID_EX_rR1, ID_EX_rR2, ID_EX_wR, ID_EX_alu_asel, ID_EX_alu_bsel,
           ID_EX_alu_op, ID_EX_rf_we, ID_EX_rf_wsel, ID_EX_ram_we,
           ID_EX_is_load, ID_EX_branch,
           stall_pc, stall_if_id, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
// ===========================================================================
// load_use_detect : flags an ID instruction whose ALU operand needs the
//                   result of the load currently sitting in EX.
// Revision 1.0
// ===========================================================================
`default_nettype none

module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_wR_i,
  input  logic       id_valid_i,
  input  logic       id_alu_asel_i,
  input  logic [1:0] id_alu_bsel_i,
  input  logic [4:0] id_rR1_i,
  input  logic [4:0] id_rR2_i,
  input  logic [4:0] id_wR_i,
  output logic       load_use_o
);

  logic w_ex_load;
  logic w_hit_a, w_hit_b, w_hit_lvrd;

  assign w_ex_load  = ex_valid_i & ex_is_load_i & (ex_wR_i != 5'd0);
  assign w_hit_a    = (id_alu_asel_i == ALU_ASEL_RD1)  & (id_rR1_i == ex_wR_i);
  assign w_hit_b    = (id_alu_bsel_i == ALU_BSEL_RD2)  & (id_rR2_i == ex_wR_i);
  // Store data is forwarded at MEM, so only the LVRD use of wR stalls here.
  assign w_hit_lvrd = (id_alu_bsel_i == ALU_BSEL_LVRD) & (id_wR_i == ex_wR_i);

  assign load_use_o = w_ex_load & id_valid_i & (w_hit_a | w_hit_b | w_hit_lvrd);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ===========================================================================
// id_ex_stage : ID/EX pipeline register with load-use interlock, branch
//               flush and wrapping stall/flush event counters.
// Revision 1.0
// ===========================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  logic             w_load_use, w_stall, w_bubble;
  ctrl_t            w_id_ctrl;

  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [DW-1:0]    pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [4:0]       rr1_q, rr1_d, rr2_q, rr2_d, wr_q, wr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_is_load_i  (ctrl_q.is_load),
    .ex_wR_i       (wr_q),
    .id_valid_i    (bus.id_valid),
    .id_alu_asel_i (bus.id_alu_asel),
    .id_alu_bsel_i (bus.id_alu_bsel),
    .id_rR1_i      (bus.id_rR1),
    .id_rR2_i      (bus.id_rR2),
    .id_wR_i       (bus.id_wR),
    .load_use_o    (w_load_use)
  );

  // A taken branch discards the ID instruction, so it must not also stall.
  assign w_stall  = w_load_use & ~bus.ex_br_taken;
  assign w_bubble = bus.ex_br_taken | w_load_use;

  assign w_id_ctrl = '{
    alu_asel: bus.id_alu_asel,
    alu_bsel: bus.id_alu_bsel,
    alu_op:   bus.id_alu_op,
    rf_we:    bus.id_rf_we,
    rf_wsel:  bus.id_rf_wsel,
    ram_we:   bus.id_ram_we,
    is_load:  bus.id_is_load,
    branch:   bus.id_branch
  };

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = CTRL_BUBBLE;
    pc_d    = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    rr1_d   = '0;
    rr2_d   = '0;
    wr_d    = '0;
    if (!w_bubble) begin
      valid_d = bus.id_valid;
      ctrl_d  = w_id_ctrl;
      pc_d    = bus.id_pc;
      rd1_d   = bus.id_rD1;
      rd2_d   = bus.id_rD2;
      imm_d   = bus.id_imm;
      rr1_d   = bus.id_rR1;
      rr2_d   = bus.id_rR2;
      wr_d    = bus.id_wR;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall)         stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bus.ex_br_taken) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_BUBBLE;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rr1_q       <= '0;
      rr2_q       <= '0;
      wr_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rr1_q       <= rr1_d;
      rr2_q       <= rr2_d;
      wr_q        <= wr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ID_EX_valid    = valid_q;
  assign bus.ID_EX_pc       = pc_q;
  assign bus.ID_EX_rD1      = rd1_q;
  assign bus.ID_EX_rD2      = rd2_q;
  assign bus.ID_EX_imm      = imm_q;
  assign bus.ID_EX_rR1      = rr1_q;
  assign bus.ID_EX_rR2      = rr2_q;
  assign bus.ID_EX_wR       = wr_q;
  assign bus.ID_EX_alu_asel = ctrl_q.alu_asel;
  assign bus.ID_EX_alu_bsel = ctrl_q.alu_bsel;
  assign bus.ID_EX_alu_op   = ctrl_q.alu_op;
  assign bus.ID_EX_rf_we    = ctrl_q.rf_we;
  assign bus.ID_EX_rf_wsel  = ctrl_q.rf_wsel;
  assign bus.ID_EX_ram_we   = ctrl_q.ram_we;
  assign bus.ID_EX_is_load  = ctrl_q.is_load;
  assign bus.ID_EX_branch   = ctrl_q.branch;
  assign bus.stall_pc       = w_stall;
  assign bus.stall_if_id    = w_stall;
  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.flush_cnt      = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ===========================================================================
// tb_id_ex_stage : directed scoreboard bench for the ID/EX stage (counters
//                  instantiated 4 bits wide so wrap-around is reachable).
// Revision 1.0
// ===========================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int DW    = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [4:0]    rr1, rr2, wr;
    logic          asel;
    logic [1:0]    bsel;
    logic [3:0]    alu_op;
    logic [1:0]    rf_we, rf_wsel, ram_we;
    logic          is_load;
    logic [1:0]    branch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] pc, input logic [4:0] rr1, input logic [4:0] rr2,
                              input logic [4:0] wr, input logic asel, input logic [1:0] bsel,
                              input logic is_load, input logic [1:0] ram_we, input logic [1:0] rf_we);
    exp_t e;
    e.valid   = 1'b1;
    e.pc      = pc;
    e.rd1     = pc + 32'h1111;
    e.rd2     = pc + 32'h2222;
    e.imm     = pc + 32'h3333;
    e.rr1     = rr1;
    e.rr2     = rr2;
    e.wr      = wr;
    e.asel    = asel;
    e.bsel    = bsel;
    e.alu_op  = pc[5:2];
    e.rf_we   = rf_we;
    e.rf_wsel = is_load ? 2'b01 : 2'b00;
    e.ram_we  = ram_we;
    e.is_load = is_load;
    e.branch  = 2'b00;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = '{valid: bus.ID_EX_valid, pc: bus.ID_EX_pc, rd1: bus.ID_EX_rD1, rd2: bus.ID_EX_rD2,
          imm: bus.ID_EX_imm, rr1: bus.ID_EX_rR1, rr2: bus.ID_EX_rR2, wr: bus.ID_EX_wR,
          asel: bus.ID_EX_alu_asel, bsel: bus.ID_EX_alu_bsel, alu_op: bus.ID_EX_alu_op,
          rf_we: bus.ID_EX_rf_we, rf_wsel: bus.ID_EX_rf_wsel, ram_we: bus.ID_EX_ram_we,
          is_load: bus.ID_EX_is_load, branch: bus.ID_EX_branch};
    return o;
  endfunction

  task automatic drive(input exp_t e, input logic br);
    bus.id_valid    = e.valid;
    bus.id_pc       = e.pc;
    bus.id_rD1      = e.rd1;
    bus.id_rD2      = e.rd2;
    bus.id_imm      = e.imm;
    bus.id_rR1      = e.rr1;
    bus.id_rR2      = e.rr2;
    bus.id_wR       = e.wr;
    bus.id_alu_asel = e.asel;
    bus.id_alu_bsel = e.bsel;
    bus.id_alu_op   = e.alu_op;
    bus.id_rf_we    = e.rf_we;
    bus.id_rf_wsel  = e.rf_wsel;
    bus.id_ram_we   = e.ram_we;
    bus.id_is_load  = e.is_load;
    bus.id_branch   = e.branch;
    bus.ex_br_taken = br;
  endtask

  // One cycle: present ins, check the interlock, then check what EX received.
  task automatic step(input string tag, input exp_t ins, input logic br, input logic exp_stall);
    exp_t e;
    @(negedge clk);
    drive(ins, br);
    #1;
    chk({tag, ".stall_pc"}, 256'(bus.stall_pc), 256'(exp_stall));
    chk({tag, ".stall_if_id"}, 256'(bus.stall_if_id), 256'(exp_stall));
    sbq.push_back((br || exp_stall) ? exp_t'('0) : ins);
    if (exp_stall) m_stall = m_stall + 1'b1;
    if (br)        m_flush = m_flush + 1'b1;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".id_ex"}, 256'(observed()), 256'(e));
    chk({tag, ".stall_cnt"}, 256'(bus.stall_cnt), 256'(m_stall));
    chk({tag, ".flush_cnt"}, 256'(bus.flush_cnt), 256'(m_flush));
  endtask

  initial begin
    exp_t lw5, add_dep, sw5, lw0, add0, lw6, add6, lvrd5, nop, lw9, use9;
    //          pc        rR1    rR2    wR     asel  bsel   ld    ram    rfwe
    lw5     = mk(32'h100, 5'd1,  5'd0,  5'd5,  1'b0, 2'b01, 1'b1, 2'b00, 2'b01);
    add_dep = mk(32'h104, 5'd5,  5'd7,  5'd6,  1'b0, 2'b00, 1'b0, 2'b00, 2'b01);
    sw5     = mk(32'h108, 5'd2,  5'd3,  5'd5,  1'b0, 2'b01, 1'b0, 2'b10, 2'b00);
    lw0     = mk(32'h10c, 5'd1,  5'd0,  5'd0,  1'b0, 2'b01, 1'b1, 2'b00, 2'b01);
    add0    = mk(32'h110, 5'd0,  5'd0,  5'd8,  1'b0, 2'b00, 1'b0, 2'b00, 2'b01);
    lw6     = mk(32'h114, 5'd5,  5'd0,  5'd6,  1'b0, 2'b01, 1'b1, 2'b00, 2'b01);
    add6    = mk(32'h118, 5'd9,  5'd6,  5'd10, 1'b1, 2'b00, 1'b0, 2'b00, 2'b01);
    lvrd5   = mk(32'h11c, 5'd3,  5'd4,  5'd5,  1'b1, 2'b10, 1'b0, 2'b00, 2'b01);
    lw9     = mk(32'h120, 5'd2,  5'd0,  5'd9,  1'b0, 2'b01, 1'b1, 2'b00, 2'b01);
    use9    = mk(32'h124, 5'd1,  5'd9,  5'd11, 1'b1, 2'b00, 1'b0, 2'b00, 2'b01);
    nop     = add_dep;
    nop.valid = 1'b0;

    drive(exp_t'('0), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.id_ex", 256'(observed()), 256'(0));
    chk("reset.stall_pc", 256'(bus.stall_pc), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    step("t2.lw5", lw5, 1'b0, 1'b0);
    step("t2.stall", add_dep, 1'b0, 1'b1);
    step("t2.capture", add_dep, 1'b0, 1'b0);

    step("t5.lw5", lw5, 1'b0, 1'b0);
    step("t5.flush", add_dep, 1'b1, 1'b0);
    step("t5.after", add_dep, 1'b0, 1'b0);

    step("t1.lw5", lw5, 1'b0, 1'b0);
    @(negedge clk);
    drive(add_dep, 1'b0);
    #1;
    chk("t1.pre_stall", 256'(bus.stall_pc), 256'(1));
    rst = 1'b1;
    #1;
    chk("t1.stall_pc", 256'(bus.stall_pc), 256'(0));
    chk("t1.stall_if_id", 256'(bus.stall_if_id), 256'(0));
    chk("t1.id_ex", 256'(observed()), 256'(0));
    chk("t1.stall_cnt", 256'(bus.stall_cnt), 256'(0));
    chk("t1.flush_cnt", 256'(bus.flush_cnt), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    m_stall = '0;
    m_flush = '0;

    for (int i = 0; i < 16; i++) begin
      step("t6.lw9", lw9, 1'b0, 1'b0);
      step("t6.stall", use9, 1'b0, 1'b1);
      step("t6.capture", use9, 1'b0, 1'b0);
    end
    chk("t6.wrap", 256'(bus.stall_cnt), 256'(0));

    step("t3.lw5", lw5, 1'b0, 1'b0);
    step("t3.sw_no_stall", sw5, 1'b0, 1'b0);

    step("t4.lw0", lw0, 1'b0, 1'b0);
    step("t4.x0_no_stall", add0, 1'b0, 1'b0);

    step("b2b.lw5", lw5, 1'b0, 1'b0);
    step("b2b.lw6_stall", lw6, 1'b0, 1'b1);
    step("b2b.lw6_cap", lw6, 1'b0, 1'b0);
    step("b2b.add6_stall", add6, 1'b0, 1'b1);
    step("b2b.add6_cap", add6, 1'b0, 1'b0);

    step("lvrd.lw5", lw5, 1'b0, 1'b0);
    step("lvrd.stall", lvrd5, 1'b0, 1'b1);
    step("lvrd.capture", lvrd5, 1'b0, 1'b0);

    step("inv.lw5", lw5, 1'b0, 1'b0);
    step("inv.no_stall", nop, 1'b0, 1'b0);
    step("inv.flush", add_dep, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
